// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
//
// Write-only SPI (mode 0) peripheral holding five 8-bit configuration
// registers. The SPI pins are asynchronous to clk. Each pin is brought in
// through a synchronizer chain. The frame is decoded entirely in the clk domain.
//
// Frame (16 bits, MSB first): [15] R/W (1 = write), [14:8] address, [7:0] data.
// A write is committed when nCS rises. The frame must have exactly 16 bits,
// R/W must be 1 and the address must be <= MAX_ADDR.
//
// Ports
//   clk              system clock, all state changes on its rising edge
//   rst_n            synchronous active-low reset
//   sclk_in          SPI clock (async, mode 0)
//   copi_in          SPI data in (async)
//   ncs_in           SPI chip select (async, active-low)
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
//   txn_done         one-cycle pulse: a write was committed
//   frame_err        one-cycle pulse: a frame with a bit count other than 16
//                    was discarded
// -----------------------------------------------------------------------------
module spi_reg_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       frame_err
);

  localparam int         NUM_REGS  = 5;
  localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Bits [SYNC_STAGES-1:0] form the synchronizer.
  // Bit [SYNC_STAGES] is the history flop used for edge detection.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES:0] sclk_pipe_q, sclk_pipe_d;
  logic [SYNC_STAGES:0] copi_pipe_q, copi_pipe_d;
  logic [SYNC_STAGES:0] ncs_pipe_q,  ncs_pipe_d;

  always_comb begin
    sclk_pipe_d = {sclk_pipe_q[SYNC_STAGES-1:0], sclk_in};
    copi_pipe_d = {copi_pipe_q[SYNC_STAGES-1:0], copi_in};
    ncs_pipe_d  = {ncs_pipe_q[SYNC_STAGES-1:0],  ncs_in};
  end

  logic sclk_sync, sclk_hist;
  logic copi_hist;
  logic ncs_sync,  ncs_hist;

  assign sclk_sync = sclk_pipe_q[SYNC_STAGES-1];
  assign sclk_hist = sclk_pipe_q[SYNC_STAGES];
  assign ncs_sync  = ncs_pipe_q[SYNC_STAGES-1];
  assign ncs_hist  = ncs_pipe_q[SYNC_STAGES];
  // COPI is taken from the history flop. The history flop is aligned with
  // sclk_hist, which is still low when a rising edge is seen. The bit
  // captured is therefore the one set up before the SCLK edge.
  assign copi_hist = copi_pipe_q[SYNC_STAGES];

  // ---------------------------------------------------------------------------
  // Arming. After reset the nCS chain is preset high. If the raw pin is
  // actually low, a false falling edge would appear once real samples reach
  // the end of the chain. Falling edges are therefore only accepted after
  // two conditions hold. First, the chain has been refilled with real
  // samples. Second, nCS has been seen high.
  // ---------------------------------------------------------------------------
  logic [2:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       fill_done;

  assign fill_done = (fill_q == FILL_DONE);

  always_comb begin
    fill_d  = fill_done ? fill_q : fill_q + 3'd1;
    armed_d = armed_q | (fill_done & ncs_sync & ncs_hist);
  end

  logic sclk_rise, ncs_fall, ncs_rise;

  assign sclk_rise = sclk_sync & ~sclk_hist;
  assign ncs_fall  = armed_q & ncs_hist & ~ncs_sync;
  assign ncs_rise  = ncs_sync & ~ncs_hist;

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        pend_q, pend_d;     // nCS falling edge seen during COMMIT
  logic        txn_done_q, txn_done_d;
  logic        frame_err_q, frame_err_d;
  logic        wr_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    pend_d      = pend_q;
    txn_done_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        // A pending edge is honoured only if nCS is still low.
        if (ncs_fall || (pend_q && !ncs_sync)) begin
          state_d = ST_SHIFT;
          cnt_d   = 5'd0;
          shreg_d = 16'h0000;
        end
      end

      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
          if (cnt_q != 5'd16) begin
            frame_err_d = 1'b1;
          end else if (shreg_q[15] && (shreg_q[14:8] <= MAX_ADDR)) begin
            wr_en      = 1'b1;
            txn_done_d = 1'b1;
          end
          // A read frame, or a write beyond MAX_ADDR, is dropped silently.
        end else if (ncs_fall) begin
          // Only reachable if a rise was missed. Restart cleanly.
          cnt_d   = 5'd0;
          shreg_d = 16'h0000;
        end else if (sclk_rise && !ncs_sync) begin
          shreg_d = {shreg_q[14:0], copi_hist};
          if (cnt_q != 5'd17) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (ncs_fall) begin
          pend_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file. A register changes only on the committing clock edge.
  // ---------------------------------------------------------------------------
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (shreg_q[14:8] == 7'(i))) begin
        regs_d[i] = shreg_q[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_pipe_q <= '0;
      copi_pipe_q <= '0;
      ncs_pipe_q  <= '1;
      fill_q      <= 3'd0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      shreg_q     <= 16'h0000;
      pend_q      <= 1'b0;
      txn_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      copi_pipe_q <= copi_pipe_d;
      ncs_pipe_q  <= ncs_pipe_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      txn_done_q  <= txn_done_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign txn_done        = txn_done_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_slave
//
// Directed testbench for spi_reg_slave with SYNC_STAGES = 2. Each scenario
// task drives SPI frames with SCLK levels and nCS gaps at the minimum legal
// length. It then compares the register outputs and pulse counts with
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_reg_slave;

  localparam int SYNC = 2;
  localparam int HALF = SYNC + 2;  // clk cycles per SCLK level
  localparam int GAP  = SYNC + 2;  // minimum nCS high gap

  logic       clk;
  logic       rst_n;
  logic       sclk_in;
  logic       copi_in;
  logic       ncs_in;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       txn_done;
  logic       frame_err;

  int tests;
  int fails;
  int txn_total;
  int err_total;
  int both_hi;

  logic [39:0] regs_now;
  assign regs_now = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                     en_reg_pwm_15_8, pwm_duty_cycle};

  spi_reg_slave #(
    .SYNC_STAGES (SYNC),
    .MAX_ADDR    (7'h04)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk_in         (sclk_in),
    .copi_in         (copi_in),
    .ncs_in          (ncs_in),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .txn_done        (txn_done),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (txn_done === 1'b1) txn_total = txn_total + 1;
    if (frame_err === 1'b1) err_total = err_total + 1;
    if (txn_done === 1'b1 && frame_err === 1'b1) both_hi = both_hi + 1;
  end

  // ---------------------------------------------------------------------------
  // SPI drivers (all called while aligned to a clk falling edge)
  // ---------------------------------------------------------------------------
  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi_in = v[i];
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [31:0] v, input int n);
    ncs_in = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(v, n);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_frame(input int gap);
    ncs_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    start_frame(v, n);
    end_frame(12);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n   = 1'b0;
    sclk_in = 1'b0;
    copi_in = 1'b0;
    ncs_in  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (regs_now !== 40'h00_00_00_00_00) begin
      fails++;
      $display("FAIL reset_regs: got %h expected %h", regs_now, 40'h0);
    end
    tests++;
    if (txn_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_txn_done: got %b expected 0", txn_done);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    $display("[TB] reset: regs=%h", regs_now);
  endtask

  task automatic test_write_basic();
    int t0;
    t0 = txn_total;
    start_frame(32'h80F0, 16);
    ncs_in = 1'b1;
    // The register must still be old SYNC edges after the raw nCS rise.
    repeat (SYNC) @(posedge clk);
    #1;
    tests++;
    if (en_reg_out_7_0 !== 8'h00) begin
      fails++;
      $display("FAIL latency_early: got %h expected 00", en_reg_out_7_0);
    end
    // The register updates on edge SYNC+1, together with txn_done.
    @(posedge clk);
    #1;
    tests++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      fails++;
      $display("FAIL latency_update: got %h expected F0", en_reg_out_7_0);
    end
    tests++;
    if (txn_done !== 1'b1) begin
      fails++;
      $display("FAIL latency_txn_done: got %b expected 1", txn_done);
    end
    @(negedge clk);
    repeat (12) @(negedge clk);
    tests++;
    if (regs_now !== 40'hF0_00_00_00_00) begin
      fails++;
      $display("FAIL write_80F0_regs: got %h expected %h", regs_now, 40'hF0_00_00_00_00);
    end
    tests++;
    if (txn_total - t0 !== 1) begin
      fails++;
      $display("FAIL write_80F0_txn: got %0d pulses expected 1", txn_total - t0);
    end
    $display("[TB] write 0x80F0: regs=%h", regs_now);

    t0 = txn_total;
    send_frame(32'h8480, 16);
    tests++;
    if (regs_now !== 40'hF0_00_00_00_80) begin
      fails++;
      $display("FAIL write_8480_regs: got %h expected %h", regs_now, 40'hF0_00_00_00_80);
    end
    tests++;
    if (txn_total - t0 !== 1) begin
      fails++;
      $display("FAIL write_8480_txn: got %0d pulses expected 1", txn_total - t0);
    end
    $display("[TB] write 0x8480: regs=%h", regs_now);
  endtask

  task automatic test_ignored();
    int t0;
    int e0;
    t0 = txn_total;
    e0 = err_total;
    send_frame(32'h8555, 16);
    tests++;
    if (regs_now !== 40'hF0_00_00_00_80) begin
      fails++;
      $display("FAIL bad_addr_regs: got %h expected %h", regs_now, 40'hF0_00_00_00_80);
    end
    tests++;
    if ((txn_total - t0) + (err_total - e0) !== 0) begin
      fails++;
      $display("FAIL bad_addr_pulses: got %0d expected 0", (txn_total - t0) + (err_total - e0));
    end
    $display("[TB] write 0x8555 (addr 5): regs=%h", regs_now);

    t0 = txn_total;
    e0 = err_total;
    send_frame(32'h0155, 16);
    tests++;
    if (regs_now !== 40'hF0_00_00_00_80) begin
      fails++;
      $display("FAIL read_regs: got %h expected %h", regs_now, 40'hF0_00_00_00_80);
    end
    tests++;
    if ((txn_total - t0) + (err_total - e0) !== 0) begin
      fails++;
      $display("FAIL read_pulses: got %0d expected 0", (txn_total - t0) + (err_total - e0));
    end
    $display("[TB] read 0x0155: regs=%h", regs_now);
  endtask

  task automatic test_frame_errors();
    int t0;
    int e0;
    t0 = txn_total;
    e0 = err_total;
    send_frame(32'h0000_0812, 12);
    send_frame(32'h0001_81BB, 17);
    tests++;
    if (err_total - e0 !== 2) begin
      fails++;
      $display("FAIL bad_len_err: got %0d pulses expected 2", err_total - e0);
    end
    tests++;
    if (txn_total - t0 !== 0) begin
      fails++;
      $display("FAIL bad_len_txn: got %0d pulses expected 0", txn_total - t0);
    end
    tests++;
    if (regs_now !== 40'hF0_00_00_00_80) begin
      fails++;
      $display("FAIL bad_len_regs: got %h expected %h", regs_now, 40'hF0_00_00_00_80);
    end
    $display("[TB] 12-bit + 17-bit frames: regs=%h", regs_now);

    t0 = txn_total;
    e0 = err_total;
    send_frame(32'h81AA, 16);
    tests++;
    if (regs_now !== 40'hF0_AA_00_00_80) begin
      fails++;
      $display("FAIL recover_81AA_regs: got %h expected %h", regs_now, 40'hF0_AA_00_00_80);
    end
    tests++;
    if ((txn_total - t0 !== 1) || (err_total - e0 !== 0)) begin
      fails++;
      $display("FAIL recover_81AA_pulses: got txn=%0d err=%0d expected 1/0",
               txn_total - t0, err_total - e0);
    end
    $display("[TB] write 0x81AA: regs=%h", regs_now);
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = txn_total;
    start_frame(32'h8211, 16);
    end_frame(GAP);
    start_frame(32'h8322, 16);
    end_frame(12);
    tests++;
    if (regs_now !== 40'hF0_AA_11_22_80) begin
      fails++;
      $display("FAIL b2b_regs: got %h expected %h", regs_now, 40'hF0_AA_11_22_80);
    end
    tests++;
    if (txn_total - t0 !== 2) begin
      fails++;
      $display("FAIL b2b_txn: got %0d pulses expected 2", txn_total - t0);
    end
    $display("[TB] back-to-back 0x8211/0x8322: regs=%h", regs_now);
  endtask

  task automatic test_mid_frame_reset();
    int t0;
    t0 = txn_total;
    ncs_in = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(32'h83, 8);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (regs_now !== 40'h00_00_00_00_00) begin
      fails++;
      $display("FAIL reset_first_edge: got %h expected %h", regs_now, 40'h0);
    end
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    // nCS is still low. The rest of the frame must not be decoded.
    shift_bits(32'hFF, 8);
    repeat (HALF) @(negedge clk);
    end_frame(12);
    tests++;
    if (regs_now !== 40'h00_00_00_00_00) begin
      fails++;
      $display("FAIL mid_reset_regs: got %h expected %h", regs_now, 40'h0);
    end
    tests++;
    if (txn_total - t0 !== 0) begin
      fails++;
      $display("FAIL mid_reset_txn: got %0d pulses expected 0", txn_total - t0);
    end
    $display("[TB] reset mid-frame 0x83FF: regs=%h", regs_now);

    t0 = txn_total;
    send_frame(32'h83FF, 16);
    tests++;
    if (regs_now !== 40'h00_00_00_FF_00) begin
      fails++;
      $display("FAIL after_reset_write_regs: got %h expected %h", regs_now, 40'h00_00_00_FF_00);
    end
    tests++;
    if (txn_total - t0 !== 1) begin
      fails++;
      $display("FAIL after_reset_write_txn: got %0d pulses expected 1", txn_total - t0);
    end
    $display("[TB] write 0x83FF after reset: regs=%h", regs_now);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    txn_total = 0;
    err_total = 0;
    both_hi   = 0;
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_ignored();
    test_frame_errors();
    test_back_to_back();
    test_mid_frame_reset();
    tests++;
    if (both_hi !== 0) begin
      fails++;
      $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", both_hi);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in each input synchronizer chain; legal values are 2 or 3.
REQ-002 Parameter MAX_ADDR, default 7'h04: the highest writable register address.
REQ-003 clk  input  1  System clock; single clock domain; all state changes on its rising edge.
REQ-004 rst_n  input  1  Reset, synchronous and active-low.
REQ-005 sclk_in  input  1  SPI serial clock, asynchronous to clk, mode 0.
REQ-006 copi_in  input  1  SPI controller-out/peripheral-in data, asynchronous to clk.
REQ-007 ncs_in  input  1  SPI chip select, asynchronous to clk, active-low.
REQ-008 en_reg_out_7_0  output  8  Register at address 0x00: output enables for outputs 7..0.
REQ-009 en_reg_out_15_8  output  8  Register at address 0x01: output enables for outputs 15..8.
REQ-010 en_reg_pwm_7_0  output  8  Register at address 0x02: PWM mode select for outputs 7..0.
REQ-011 en_reg_pwm_15_8  output  8  Register at address 0x03: PWM mode select for outputs 15..8.
REQ-012 pwm_duty_cycle  output  8  Register at address 0x04: PWM duty cycle, where 0x00 = 0% and 0xFF = 100%.
REQ-013 txn_done  output  1  One-clk pulse: a valid write was committed.
REQ-014 frame_err  output  1  One-clk pulse: a frame was discarded.

Function
REQ-015 Each of sclk_in, copi_in and ncs_in SHALL pass through a SYNC_STAGES flip-flop synchronizer plus one extra history flip-flop, used for edge detection.
REQ-016 Frame start: the falling edge of synchronized nCS SHALL clear the bit counter (5 bits) and the 16-bit shift register.
REQ-017 Sampling: on each synchronized SCLK rising edge while synchronized nCS is low, the block SHALL shift synchronized COPI into the shift register LSB, MSB first, and increment the counter.
REQ-018 The counter SHALL saturate at 17; any further edges SHALL NOT wrap the counter.
REQ-019 SCLK edges while synchronized nCS is high SHALL be ignored.
REQ-020 Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-021 Commit: on the clk cycle in which the synchronized nCS rising edge is detected, if all three conditions below hold, the addressed register SHALL load the data byte on that clock edge and txn_done SHALL pulse high for exactly that one cycle:
- counter == 16
- bit15 == 1
- address <= MAX_ADDR
REQ-022 Counter != 16 at the nCS rising edge: no register SHALL change, and frame_err SHALL pulse for one cycle.
REQ-023 Read frame (bit15 = 0) with exactly 16 bits: the frame SHALL be ignored, with no register change and no txn_done or frame_err pulse; this block has no MISO output.
REQ-024 Write frame with address > MAX_ADDR and exactly 16 bits: it SHALL be ignored silently, with no pulses.
REQ-025 txn_done and frame_err SHALL be mutually exclusive.
REQ-026 State machine states: IDLE (nCS high), SHIFT (nCS low, counting), COMMIT (one cycle).
- IDLE -> SHIFT on the nCS falling edge.
- SHIFT -> COMMIT on the nCS rising edge.
- COMMIT -> IDLE unconditionally.
- An nCS falling edge detected during COMMIT SHALL be honoured on the next cycle (IDLE); it SHALL NOT be lost.
REQ-027 Register outputs SHALL change only at a commit and SHALL hold their value otherwise, including throughout a frame in progress.
REQ-028 Timing: correct operation SHALL be guaranteed when each SCLK high and low level, and each nCS high gap, lasts at least SYNC_STAGES+2 clk cycles, and COPI is stable for at least the same time around the SCLK rising edge.
REQ-029 Latency: the register updates SYNC_STAGES+1 clk cycles after the raw ncs_in rising edge.

Reset
REQ-030 While rst_n is low at a clk rising edge, the block SHALL clear all five registers to 0x00 and also clear:
- the counter, the shift register and all synchronizer flops (synchronized nCS held at 1);
- txn_done and frame_err (both 0);
- the state machine, which returns to IDLE.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame.
- After reset release with raw nCS still low, no SHIFT SHALL start until a fresh nCS falling edge is seen.
REQ-032 Register outputs SHALL be 0x00 starting from the first clk edge with rst_n low.

Verification
REQ-033 After reset, with no SPI activity -> all five registers = 0x00, txn_done = 0, frame_err = 0.
REQ-034 Write frame 0x80F0 -> en_reg_out_7_0 = 0xF0, one txn_done pulse, other registers unchanged.
- Then write frame 0x8480 -> pwm_duty_cycle = 0x80.
REQ-035 Write frame 0x8555 (address 0x05) -> all registers unchanged, no pulses.
- Read frame 0x0155 -> all registers unchanged, no pulses.
REQ-036 Short frame of 12 bits, then a 17-bit frame -> two frame_err pulses, no register change.
- A following valid frame 0x81AA -> en_reg_out_15_8 = 0xAA.
REQ-037 Assert rst_n low after 8 bits of frame 0x83FF, release it, then complete the remaining SCLK pulses and raise nCS -> en_reg_pwm_15_8 = 0x00, no txn_done pulse.
REQ-038 Back-to-back frames 0x8211 and 0x8322 with the minimum nCS high gap -> en_reg_pwm_7_0 = 0x11, en_reg_pwm_15_8 = 0x22, two txn_done pulses.
